// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared state, opcode, command and select encodings for the multicycle controller
package mc_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;
  localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_ORR = 2'b11;
  localparam logic [1:0] OP_DP = 2'b00, OP_MEM = 2'b01, OP_BR = 2'b10, OP_ILL = 2'b11;
  localparam logic [3:0] CMD_AND = 4'b0000, CMD_SUB = 4'b0010, CMD_ADD = 4'b0100,
                         CMD_CMP = 4'b1010, CMD_ORR = 4'b1100;
  localparam logic [1:0] RES_OUT = 2'b00, RES_RD = 2'b01, RES_ALU = 2'b10;
  localparam logic [1:0] SRCB_REG = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
endpackage

// File: rtl/mc_alu_decoder.sv
// mc_alu_decoder: cmd/S field to ALU control, flag-group write enables and CMP write suppression
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic       active,
  input  logic [4:0] funct,
  output logic [1:0] alu_control,
  output logic [1:0] flag_w,
  output logic       no_write
);
  logic [3:0] cmd;
  logic cmp, s, known;
  assign cmd = funct[4:1];
  assign cmp = cmd == CMD_CMP;
  assign s = funct[0] | cmp;
  assign known = cmd inside {CMD_AND, CMD_SUB, CMD_ADD, CMD_CMP, CMD_ORR};
  assign alu_control = !active ? ALU_ADD :
                       (cmd == CMD_SUB || cmp) ? ALU_SUB :
                       cmd == CMD_AND ? ALU_AND :
                       cmd == CMD_ORR ? ALU_ORR : ALU_ADD;
  // unrecognised commands fall back to add but never touch the flags
  assign flag_w = (active && known) ?
                  {s, s & (alu_control == ALU_ADD || alu_control == ALU_SUB)} : 2'b00;
  assign no_write = active & cmp;
endmodule

// File: rtl/multicycle_main_fsm.sv
// multicycle_main_fsm: Moore main controller for the multicycle ARM-subset datapath.
// Define MEM_WAIT_EN to add mem_ready, which stalls FETCH/MEMRD/MEMWR until memory is ready.
module multicycle_main_fsm
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
`ifdef MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic [1:0] FlagW,
  output logic       RegW,
  output logic       MemW,
  output logic       PCS,
  output logic       NoWrite,
  output logic       illegal_op,
  output logic [3:0] state_o
);
  state_t state, state_n;
  logic ready, fetch, decode, memadr, memrd, memwb, memwr, execr, execi, aluwb, branch;
  logic [1:0] flag_w_raw;
`ifdef MEM_WAIT_EN
  assign ready = mem_ready;
`else
  assign ready = 1'b1;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S_FETCH;
    else state <= state_n;
  always_comb begin
    state_n = S_FETCH;
    case (state)
      S_FETCH:  state_n = ready ? S_DECODE : S_FETCH;
      S_DECODE: state_n = Op == OP_MEM ? S_MEMADR :
                          Op == OP_DP  ? (Funct[5] ? S_EXECI : S_EXECR) :
                          Op == OP_BR  ? S_BRANCH : S_FETCH;
      S_MEMADR: state_n = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_n = ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_n = ready ? S_FETCH : S_MEMWR;
      S_EXECR, S_EXECI: state_n = S_ALUWB;
      default:  state_n = S_FETCH;
    endcase
  end
  assign fetch  = state == S_FETCH;
  assign decode = state == S_DECODE;
  assign memadr = state == S_MEMADR;
  assign memrd  = state == S_MEMRD;
  assign memwb  = state == S_MEMWB;
  assign memwr  = state == S_MEMWR;
  assign execr  = state == S_EXECR;
  assign execi  = state == S_EXECI;
  assign aluwb  = state == S_ALUWB;
  assign branch = state == S_BRANCH;
  mc_alu_decoder u_alu_dec (
    .active      (execr | execi),
    .funct       (Funct[4:0]),
    .alu_control (ALUControl),
    .flag_w      (flag_w_raw),
    .no_write    (NoWrite)
  );
  // strobes are gated by rst so nothing fires while reset holds the FSM in FETCH
  assign IRWrite    = rst & fetch & ready;
  assign NextPC     = rst & fetch & ready;
  assign RegW       = rst & (memwb | aluwb);
  assign MemW       = rst & memwr & ready;
  assign PCS        = rst & (branch | (Rd == 4'hF & (memwb | aluwb)));
  assign FlagW      = rst ? flag_w_raw : 2'b00;
  assign illegal_op = rst & decode & (Op == OP_ILL);
  assign AdrSrc     = memrd | memwr;
  assign ALUSrcA    = fetch | decode;
  assign ALUSrcB    = (fetch | decode) ? SRCB_FOUR : (memadr | execi | branch) ? SRCB_IMM : SRCB_REG;
  assign ResultSrc  = (fetch | decode | branch) ? RES_ALU : memwb ? RES_RD : RES_OUT;
  assign ImmSrc     = Op;
  assign RegSrc     = {Op == OP_BR, Op == OP_MEM};
  assign state_o    = state;
endmodule

// File: tb/tb_multicycle_main_fsm.sv
// tb_multicycle_main_fsm: directed checks of state sequencing, strobes and ALU decode
module tb_multicycle_main_fsm;
  logic clk = 1'b0, rst = 1'b0;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'b0;
  logic [3:0] Rd = 4'h0;
  logic IRWrite, NextPC, AdrSrc, ALUSrcA, RegW, MemW, PCS, NoWrite, illegal_op;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, FlagW;
  logic [3:0] state_o;
  int checks = 0, errors = 0;
`ifdef MEM_WAIT_EN
  logic mem_ready = 1'b1;
`endif

  always #5 clk = ~clk;

  multicycle_main_fsm dut (
    .clk(clk), .rst(rst),
`ifdef MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .Op(Op), .Funct(Funct), .Rd(Rd),
    .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .ALUControl(ALUControl), .FlagW(FlagW), .RegW(RegW), .MemW(MemW), .PCS(PCS),
    .NoWrite(NoWrite), .illegal_op(illegal_op), .state_o(state_o)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    checks++; if ({IRWrite, NextPC, RegW, MemW, PCS, FlagW, illegal_op} !== 8'b0) begin errors++; $display("FAIL reset_strobes got=%b exp=0", {IRWrite, NextPC, RegW, MemW, PCS, FlagW, illegal_op}); end
    rst = 1'b1;
    #1;
    checks++; if ({IRWrite, NextPC, ALUSrcA, ALUSrcB, ResultSrc} !== 7'b1111010) begin errors++; $display("FAIL reset_release_fetch got=%b exp=1111010", {IRWrite, NextPC, ALUSrcA, ALUSrcB, ResultSrc}); end
  endtask

  task automatic test_add;
    Op = 2'b00; Funct = 6'b001001; Rd = 4'h3;
    tick;
    checks++; if (state_o !== 4'd1 || IRWrite !== 1'b0) begin errors++; $display("FAIL add_decode state=%0d irw=%b exp=1/0", state_o, IRWrite); end
    tick;
    checks++; if (state_o !== 4'd6) begin errors++; $display("FAIL add_execr_state got=%0d exp=6", state_o); end
    checks++; if ({ALUControl, FlagW, NoWrite, ALUSrcB} !== 7'b0011000) begin errors++; $display("FAIL add_execr_ctl got=%b exp=0011000", {ALUControl, FlagW, NoWrite, ALUSrcB}); end
    tick;
    checks++; if (state_o !== 4'd8 || RegW !== 1'b1 || PCS !== 1'b0 || ResultSrc !== 2'b00 || FlagW !== 2'b00) begin errors++; $display("FAIL add_aluwb state=%0d regw=%b pcs=%b res=%b flagw=%b exp=8/1/0/00/00", state_o, RegW, PCS, ResultSrc, FlagW); end
    tick;
    checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL add_return got=%0d exp=0", state_o); end
  endtask

  task automatic test_cmp_imm;
    Op = 2'b00; Funct = 6'b110101; Rd = 4'h0;
    tick; tick;
    checks++; if (state_o !== 4'd7 || ALUSrcB !== 2'b01) begin errors++; $display("FAIL cmp_execi state=%0d srcb=%b exp=7/01", state_o, ALUSrcB); end
    checks++; if ({ALUControl, FlagW, NoWrite} !== 5'b01111) begin errors++; $display("FAIL cmp_ctl got=%b exp=01111", {ALUControl, FlagW, NoWrite}); end
    tick;
    checks++; if (state_o !== 4'd8 || NoWrite !== 1'b0) begin errors++; $display("FAIL cmp_aluwb state=%0d nowrite=%b exp=8/0", state_o, NoWrite); end
    tick;
  endtask

  task automatic test_alu_decode;
    logic [5:0] fn [5] = '{6'b000100, 6'b000000, 6'b011001, 6'b000011, 6'b010100};
    logic [4:0] exp [5] = '{5'b01000, 5'b10000, 5'b11100, 5'b00000, 5'b01111};
    for (int i = 0; i < 5; i++) begin
      Op = 2'b00; Funct = fn[i];
      tick; tick;
      checks++; if (state_o !== 4'd6 || {ALUControl, FlagW, NoWrite} !== exp[i]) begin errors++; $display("FAIL alu_dec[%0d] state=%0d ctl=%b exp=6/%b", i, state_o, {ALUControl, FlagW, NoWrite}, exp[i]); end
      tick; tick;
    end
  endtask

  task automatic test_ldr;
    Op = 2'b01; Funct = 6'b011001; Rd = 4'hF;
    tick;
    checks++; if (state_o !== 4'd1 || RegSrc !== 2'b01 || ImmSrc !== 2'b01) begin errors++; $display("FAIL ldr_decode state=%0d regsrc=%b immsrc=%b exp=1/01/01", state_o, RegSrc, ImmSrc); end
    tick;
    checks++; if (state_o !== 4'd2 || ALUSrcB !== 2'b01 || ALUSrcA !== 1'b0) begin errors++; $display("FAIL ldr_memadr state=%0d srcb=%b srca=%b exp=2/01/0", state_o, ALUSrcB, ALUSrcA); end
    tick;
    checks++; if (state_o !== 4'd3 || AdrSrc !== 1'b1 || RegW !== 1'b0) begin errors++; $display("FAIL ldr_memrd state=%0d adr=%b regw=%b exp=3/1/0", state_o, AdrSrc, RegW); end
    tick;
    checks++; if (state_o !== 4'd4 || {RegW, PCS, ResultSrc} !== 4'b1101) begin errors++; $display("FAIL ldr_memwb state=%0d got=%b exp=4/1101", state_o, {RegW, PCS, ResultSrc}); end
    tick;
    checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL ldr_return got=%0d exp=0", state_o); end
  endtask

  task automatic test_str;
    Op = 2'b01; Funct = 6'b011000; Rd = 4'h2;
    tick; tick; tick;
    checks++; if (state_o !== 4'd5 || MemW !== 1'b1 || AdrSrc !== 1'b1 || RegW !== 1'b0) begin errors++; $display("FAIL str_memwr state=%0d memw=%b adr=%b regw=%b exp=5/1/1/0", state_o, MemW, AdrSrc, RegW); end
    tick;
    checks++; if (state_o !== 4'd0 || MemW !== 1'b0) begin errors++; $display("FAIL str_return state=%0d memw=%b exp=0/0", state_o, MemW); end
  endtask

  task automatic test_branch;
    Op = 2'b10; Funct = 6'b0; Rd = 4'h0;
    tick;
    checks++; if (RegSrc !== 2'b10 || ImmSrc !== 2'b10) begin errors++; $display("FAIL br_regsrc got=%b/%b exp=10/10", RegSrc, ImmSrc); end
    tick;
    checks++; if (state_o !== 4'd9 || {PCS, ALUSrcB, ResultSrc, RegW} !== 6'b101100) begin errors++; $display("FAIL br_state state=%0d got=%b exp=9/101100", state_o, {PCS, ALUSrcB, ResultSrc, RegW}); end
    tick;
    checks++; if (state_o !== 4'd0 || PCS !== 1'b0) begin errors++; $display("FAIL br_return state=%0d pcs=%b exp=0/0", state_o, PCS); end
  endtask

  task automatic test_illegal;
    Op = 2'b11;
    checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL ill_fetch got=%b exp=0", illegal_op); end
    tick;
    checks++; if (state_o !== 4'd1 || illegal_op !== 1'b1) begin errors++; $display("FAIL ill_decode state=%0d ill=%b exp=1/1", state_o, illegal_op); end
    tick;
    checks++; if (state_o !== 4'd0 || illegal_op !== 1'b0 || IRWrite !== 1'b1) begin errors++; $display("FAIL ill_return state=%0d ill=%b irw=%b exp=0/0/1", state_o, illegal_op, IRWrite); end
  endtask

  task automatic test_reset_mid_str;
    Op = 2'b01; Funct = 6'b011000; Rd = 4'h1;
    tick; tick; tick;
    checks++; if (state_o !== 4'd5) begin errors++; $display("FAIL midrst_reach got=%0d exp=5", state_o); end
    #2 rst = 1'b0;
    #1;
    checks++; if (state_o !== 4'd0 || MemW !== 1'b0 || IRWrite !== 1'b0) begin errors++; $display("FAIL midrst_async state=%0d memw=%b irw=%b exp=0/0/0", state_o, MemW, IRWrite); end
    tick;
    rst = 1'b1;
    #1;
    checks++; if (state_o !== 4'd0 || IRWrite !== 1'b1) begin errors++; $display("FAIL midrst_release state=%0d irw=%b exp=0/1", state_o, IRWrite); end
    Op = 2'b00; Funct = 6'b001000;
    tick;
    checks++; if (state_o !== 4'd1) begin errors++; $display("FAIL midrst_resume got=%0d exp=1", state_o); end
    tick; tick; tick;
  endtask

`ifdef MEM_WAIT_EN
  task automatic test_mem_wait;
    Op = 2'b00; Funct = 6'b001000;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++; if (state_o !== 4'd0 || IRWrite !== 1'b0 || NextPC !== 1'b0 || ALUSrcB !== 2'b10) begin errors++; $display("FAIL wait_hold[%0d] state=%0d irw=%b npc=%b srcb=%b exp=0/0/0/10", i, state_o, IRWrite, NextPC, ALUSrcB); end
    end
    mem_ready = 1'b1;
    #1;
    checks++; if (IRWrite !== 1'b1 || NextPC !== 1'b1) begin errors++; $display("FAIL wait_ready irw=%b npc=%b exp=1/1", IRWrite, NextPC); end
    tick;
    checks++; if (state_o !== 4'd1 || IRWrite !== 1'b0) begin errors++; $display("FAIL wait_decode state=%0d irw=%b exp=1/0", state_o, IRWrite); end
    tick; tick; tick;
  endtask
`endif

  initial begin
    test_reset;
    test_add;
    test_cmp_imm;
    test_alu_decode;
    test_ldr;
    test_str;
    test_branch;
    test_illegal;
    test_reset_mid_str;
`ifdef MEM_WAIT_EN
    test_mem_wait;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
